// File: rtl/bus_arb_router.sv
// Single-bus arbiter/router: pops one packet from an arbitrated source FIFO and
// pushes it to a decoded destination, or to every other device on broadcast.
module bus_arb_router #(
  parameter int         drvrs     = 5,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'h07,
  parameter bit         arb_mode  = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  input  logic [drvrs-1:0]                full,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push,
  output logic                            busy,
  output logic [15:0]                     pkt_cnt,
  output logic [7:0]                      drop_cnt
);

  localparam int IW = $clog2(drvrs);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, PUSH} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [IW-1:0]        last_q, last_d;
  logic [pckg_sz-1:0]   pkt_q, pkt_d;
  logic [15:0]          pkt_cnt_q, pkt_cnt_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic [IW-1:0]        arb_idx;
  logic [IW:0]          cand;
  logic                 found;
  logic [7:0]           dest;
  logic [drvrs-1:0]     mask;
  logic                 dest_ok;
  logic                 blocked;

  // Round-robin searches last+1 .. last+drvrs modulo drvrs; fixed mode takes the lowest index.
  always_comb begin
    arb_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (arb_mode) begin
      for (int k = drvrs - 1; k >= 0; k--) begin
        if (pndng[k]) arb_idx = IW'(k);
      end
    end else begin
      for (int k = 1; k <= drvrs; k++) begin
        cand = {1'b0, last_q} + (IW+1)'(k);
        if (cand >= (IW+1)'(drvrs)) cand = cand - (IW+1)'(drvrs);
        if (!found && pndng[cand[IW-1:0]]) begin
          arb_idx = cand[IW-1:0];
          found   = 1'b1;
        end
      end
    end
  end

  assign dest = pkt_q[pckg_sz-1 -: 8];

  always_comb begin
    mask    = '0;
    dest_ok = 1'b0;
    if (dest == broadcast) begin
      mask    = ~({{(drvrs-1){1'b0}}, 1'b1} << grant_q);
      dest_ok = 1'b1;
    end else if (int'(dest) < drvrs && dest != 8'(grant_q)) begin
      mask    = {{(drvrs-1){1'b0}}, 1'b1} << dest;
      dest_ok = 1'b1;
    end
  end

  // Broadcast waits until every target is ready, so it is never partially delivered.
  assign blocked = |(mask & full);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(drvrs - 1);
      pkt_q      <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      pkt_q      <= pkt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    pkt_d      = pkt_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (|pndng) begin
          grant_d = arb_idx;
          last_d  = arb_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        pkt_d   = D_pop[grant_q];
        state_d = WAIT;
      end
      WAIT: begin
        if (!dest_ok) begin
          if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
          state_d = IDLE;
        end else if (!blocked) begin
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop  = '0;
    push = '0;
    busy = (state_q != IDLE);
    if (state_q == GRANT) pop[grant_q] = 1'b1;
    if (state_q == PUSH)  push = mask;
  end

  assign D_push   = pkt_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_arb_router.sv
// Randomized and directed bench for bus_arb_router against a transaction-level model.
module tb_bus_arb_router;

  localparam int N = 5;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        pndng;
  logic [N-1:0]        full;
  logic [N-1:0][W-1:0] d_pop;

  logic [N-1:0] pop0, push0, pop1, push1;
  logic [W-1:0] dpush0, dpush1;
  logic         busy0, busy1;
  logic [15:0]  pc0, pc1;
  logic [7:0]   dc0, dc1;

  int vectors = 0;
  int errors  = 0;
  int m_last;
  int m_pkt;
  int m_drop;

  bus_arb_router #(.drvrs(N), .pckg_sz(W), .broadcast(8'h07), .arb_mode(1'b0)) u_rr (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop0), .full(full),
    .push(push0), .D_push(dpush0), .busy(busy0), .pkt_cnt(pc0), .drop_cnt(dc0)
  );

  bus_arb_router #(.drvrs(N), .pckg_sz(W), .broadcast(8'h07), .arb_mode(1'b1)) u_fp (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop1), .full(full),
    .push(push1), .D_push(dpush1), .busy(busy1), .pkt_cnt(pc1), .drop_cnt(dc1)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // First requester after the previous grant, wrapping around the device ring.
  function automatic int model_grant(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      if (p[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // One packet from IDLE back to IDLE; blocks = number of WAIT cycles held off by full.
  task automatic do_pkt(input logic [N-1:0] pnd, input int blocks, input logic [N-1:0] bfull,
                        input bit arb_chk);
    int           g;
    int           dest;
    logic [W-1:0] pkt;
    logic [N-1:0] mask, blk, epop, nonblk;
    bit           ok;
    pndng  = pnd;
    full   = arb_chk ? '0 : N'($urandom);
    g      = model_grant(pnd, m_last);
    m_last = g;
    pkt    = d_pop[g];
    dest   = int'(pkt[W-1 -: 8]);
    mask   = '0;
    ok     = 1'b1;
    if (dest == 7) begin
      mask    = '1;
      mask[g] = 1'b0;
    end else if (dest < N && dest != g) begin
      mask[dest] = 1'b1;
    end else begin
      ok = 1'b0;
    end
    epop    = '0;
    epop[g] = 1'b1;

    tick();
    check_val("grant_pop", pop0, epop);
    check_val("grant_push", push0, 0);
    check_val("grant_busy", busy0, 1);
    if (arb_chk) begin
      check_val("fixed_prio_pop", pop1, 5'b00001);
    end else begin
      pndng = N'($urandom);
      for (int i = 0; i < N; i++) if (i != g) d_pop[i] = W'($urandom);
    end

    blk = bfull & mask;
    if (blk == 0) blk = mask & (-mask);
    nonblk = arb_chk ? '0 : (N'($urandom) & ~mask);
    full   = (blocks > 0) ? (blk | nonblk) : nonblk;

    tick();
    check_val("wait_pop", pop0, 0);
    check_val("wait_push", push0, 0);
    check_val("wait_dpush", dpush0, pkt);
    check_val("wait_busy", busy0, 1);

    if (!ok) begin
      tick();
      if (m_drop < 255) m_drop++;
      check_val("drop_busy", busy0, 0);
      check_val("drop_push", push0, 0);
      check_val("drop_cnt", dc0, m_drop);
      check_val("drop_pkt_cnt", pc0, m_pkt);
      return;
    end

    for (int i = 0; i < blocks; i++) begin
      tick();
      check_val("blocked_push", push0, 0);
      check_val("blocked_busy", busy0, 1);
      full = (i == blocks - 1) ? (N'($urandom) & ~mask) : (blk | (N'($urandom) & ~mask));
    end

    tick();
    check_val("push_mask", push0, mask);
    check_val("push_data", dpush0, pkt);
    check_val("push_pop", pop0, 0);

    tick();
    if (m_pkt < 65535) m_pkt++;
    check_val("done_busy", busy0, 0);
    check_val("done_push", push0, 0);
    check_val("pkt_cnt", pc0, m_pkt);
    check_val("done_drop_cnt", dc0, m_drop);
  endtask

  initial begin
    reset = 1'b1;
    pndng = '0;
    full  = '0;
    d_pop = '0;
    m_last = N - 1;
    m_pkt  = 0;
    m_drop = 0;
    repeat (2) @(negedge clk);
    check_val("rst_pop", pop0, 0);
    check_val("rst_push", push0, 0);
    check_val("rst_busy", busy0, 0);
    check_val("rst_dpush", dpush0, 0);
    check_val("rst_pkt_cnt", pc0, 0);
    check_val("rst_drop_cnt", dc0, 0);
    reset = 1'b0;
    tick();

    // All devices requesting broadcasts: rotation on u_rr, device 0 every time on u_fp.
    for (int i = 0; i < N; i++) d_pop[i] = {8'h07, 8'(i)};
    repeat (6) do_pkt(5'b11111, 0, '0, 1'b1);

    d_pop[1] = 16'h03AB;
    do_pkt(5'b00010, 0, '0, 1'b0);
    d_pop[0] = 16'h0755;
    do_pkt(5'b00001, 0, '0, 1'b0);
    d_pop[4] = 16'h02CD;
    do_pkt(5'b10000, 10, 5'b00100, 1'b0);
    d_pop[0] = 16'h0711;
    do_pkt(5'b00001, 6, 5'b01000, 1'b0);
    d_pop[1] = 16'h0912;
    do_pkt(5'b00010, 0, '0, 1'b0);
    d_pop[1] = 16'h0134;
    do_pkt(5'b00010, 0, '0, 1'b0);
    check_val("two_drops", dc0, 2);

    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        int dst;
        r = int'($urandom_range(0, 9));
        if (r < 6)      dst = int'($urandom_range(0, N - 1));
        else if (r < 8) dst = 7;
        else            dst = int'($urandom_range(8, 255));
        d_pop[i] = {8'(dst), 8'($urandom)};
      end
      if ($urandom_range(0, 3) == 0) begin
        pndng = '0;
        tick();
        check_val("gap_busy", busy0, 0);
      end
      do_pkt(N'($urandom_range(1, 31)), int'($urandom_range(0, 3)), N'($urandom), 1'b0);
    end

    // Drive the drop counter into saturation.
    for (int n = 0; n < 260; n++) begin
      d_pop[2] = 16'hFF00 | 16'(n & 8'hFF);
      do_pkt(5'b00100, 0, '0, 1'b0);
    end
    check_val("drop_saturated", dc0, 8'hFF);

    // Reset while WAIT is held off by full: outputs must clear before the next edge.
    pndng    = 5'b10000;
    d_pop[4] = 16'h02CD;
    full     = 5'b00100;
    tick();
    tick();
    tick();
    check_val("pre_rst_busy", busy0, 1);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_pop", pop0, 0);
    check_val("async_rst_push", push0, 0);
    check_val("async_rst_busy", busy0, 0);
    check_val("async_rst_dpush", dpush0, 0);
    check_val("async_rst_pkt_cnt", pc0, 0);
    check_val("async_rst_drop_cnt", dc0, 0);
    @(negedge clk);
    reset  = 1'b0;
    m_last = N - 1;
    m_pkt  = 0;
    m_drop = 0;
    full   = '0;
    for (int i = 0; i < N; i++) d_pop[i] = {8'h07, 8'(i)};
    do_pkt(5'b11111, 0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bus_arb_router.md
# bus_arb_router

Parametrised single-bus arbiter and packet router for `drvrs` FIFO-attached devices.
- Arbitrates among devices with `pndng` set, pops one packet from the winner, decodes the 8-bit destination ID in the packet's top byte, and pushes the packet to one destination or to all other devices on broadcast.
- New relative to the current bus generator:
  - selectable round-robin or fixed-priority arbitration;
  - per-destination `full` backpressure, with all-or-nothing broadcast;
  - invalid-destination dropping;
  - delivered and dropped packet counters.

## Interface
- `drvrs`, 5: number of attached devices (2..32).
- `pckg_sz`, 16: packet width in bits (≥ 9); destination ID = `pkt[pckg_sz-1 -: 8]`.
- `broadcast`, 8'h07: destination ID meaning "all devices except source"; must be ≥ `drvrs`.
- `arb_mode`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pndng`  in  [drvrs-1:0]  device i has a packet at its FIFO head.
- `D_pop`  in  [drvrs-1:0][pckg_sz-1:0]  FIFO head data per device (first-word-fall-through).
- `pop`  out  [drvrs-1:0]  one-cycle pop strobe to the granted device.
- `full`  in  [drvrs-1:0]  destination i cannot accept a push this cycle.
- `push`  out  [drvrs-1:0]  push strobes to destinations.
- `D_push`  out  [pckg_sz-1:0]  packet data, common to all destinations.
- `busy`  out  1  FSM not in IDLE.
- `pkt_cnt`  out  16  delivered packets, saturating at 16'hFFFF.
- `drop_cnt`  out  8  dropped packets, saturating at 8'hFF.

## Operation
FSM states: IDLE, GRANT, WAIT, PUSH.
- **IDLE**
  - If `pndng != 0`, compute grant `g` and register it; go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `pop[g]=1` for exactly this cycle.
  - Capture `D_pop[g]` into the packet register; go to WAIT.
- **WAIT**: decode `dest` from the packet register.
  - `dest == broadcast`: target mask = all ones except bit `g`.
  - `dest < drvrs` and `dest != g`: target mask = one-hot `dest`.
  - Otherwise (out of range, or self-addressed): drop the packet, increment `drop_cnt`, go to IDLE.
  - If `(mask & full) == 0`, go to PUSH. Otherwise stay in WAIT indefinitely.
  - Broadcast never partially delivers.
- **PUSH**
  - `push = mask` for one cycle; `D_push` = packet register (held stable in WAIT and PUSH).
  - Increment `pkt_cnt` by 1 per packet; a broadcast counts as one.
  - Go to IDLE.
- **Round-robin arbitration**
  - Pointer `last` holds the previous grant.
  - Search starts at `last+1`, wraps modulo `drvrs`, and picks the first set `pndng` bit.
  - `last` updates on every grant.
- **Fixed-priority arbitration**: lowest set index; `last` unused.
- `pndng` changes are ignored outside IDLE.
- A source with `pndng` still set after its pop is re-arbitrated normally.

## Timing
- Reset values: `pop=0`, `push=0`, `D_push=0`, `busy=0`, `pkt_cnt=0`, `drop_cnt=0`, state IDLE, `last=drvrs-1` (first round-robin grant goes to device 0).
- Reset is asynchronous: outputs clear immediately on `reset` rising, regardless of the clock.
- Reset mid-operation discards the in-flight packet. It has already been popped from the source and is not re-pushed.
- Uncongested latency, with cycle 0 = the first rising edge where IDLE samples `pndng`:
  - `pop` asserted in cycle 1;
  - WAIT in cycle 2;
  - `push` in cycle 3.
- Back-to-back throughput: one packet per 4 cycles. IDLE re-samples `pndng` in cycle 4.
- Dropped packets occupy 3 cycles: IDLE, GRANT, WAIT.
- `full` is sampled combinationally in WAIT. `push` is asserted in the cycle after the first WAIT cycle in which all targets are not full.
- `pop` and `push` are never asserted in the same cycle.
- At most one `pop` bit is set at any time.
- Counter saturation: increments at max value are ignored.

## Test plan
All scenarios use `drvrs=5`, `pckg_sz=16`, `broadcast=8'h07`.
- Unicast: `pndng[1]=1`, `D_pop[1]=16'h03AB`, `full=0` -> `pop=5'b00010` at cycle 1; `push=5'b01000` with `D_push=16'h03AB` at cycle 3; `pkt_cnt=1`.
- Broadcast: `pndng[0]=1`, `D_pop[0]=16'h0755` -> `push=5'b11110` for one cycle; `pkt_cnt` increments by 1.
- Arbitration: `pndng=5'b11111` held, all destinations valid:
  - `arb_mode=0`: grants 0,1,2,3,4,0 in order;
  - `arb_mode=1`: grants 0 every time.
- Backpressure:
  - `full[2]=1` for 10 cycles, packet 16'h02CD from device 4 -> `busy=1` and `push=0` throughout; `push=5'b00100` in the cycle after `full[2]` falls.
  - Broadcast with `full[3]=1` -> no push bits at all until `full[3]` falls.
- Drops: dest 8'h09 from device 1, then dest 8'h01 from device 1 -> `pop` occurs both times, `push` never asserts, `drop_cnt=2`, `pkt_cnt` unchanged.
- Reset mid-op: assert `reset` while in WAIT with `full` blocking -> `push`, `pop`, `busy` and counters read 0 before the next clock edge; after release, `pndng=5'b11111` grants device 0 first.
